spi_msg_scheduler: RTL and testbench

//  Round-robin scheduler draining the slave (MISO) FIFOs of N_CH SPI interface channels into one byte stream.

---
 rtl/spi_msg_scheduler.sv | 193 +++++++++++++++++++
 tb/tb_spi_msg_scheduler.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_msg_scheduler.sv
// Round-robin scheduler framing per-channel SPI slave FIFO messages into one byte stream.
// Optional checksum byte after the payload is enabled with `define SPI_SCHED_CHECKSUM_EN.
module spi_msg_scheduler #(
  parameter int         N_CH      = 4,
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter logic [7:0] ID_BASE   = 8'h10
) (
  input  logic              sys_clk,
  input  logic              n_rst,
  input  logic [N_CH-1:0]   have_msg,
  input  logic [8*N_CH-1:0] len,
  input  logic [8*N_CH-1:0] out_data,
  output logic [N_CH-1:0]   enc_rdreq,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic [3:0]        cur_ch
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_ID,
    S_LEN,
`ifdef SPI_SCHED_CHECKSUM_EN
    S_DATA,
    S_CSUM
`else
    S_DATA
`endif
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] cur_ch_q, cur_ch_d;
  logic [7:0] cnt_q, cnt_d;
`ifdef SPI_SCHED_CHECKSUM_EN
  logic [7:0] csum_q, csum_d;
`endif

  logic       hit;
  logic [3:0] winner;
  logic [4:0] cand;
  logic [7:0] win_len;
  logic [7:0] head;

  // Search starts just after the last grant so every waiting channel is served in turn.
  always_comb begin
    hit    = 1'b0;
    winner = cur_ch_q;
    cand   = '0;
    for (int i = 1; i <= N_CH; i++) begin
      cand = {1'b0, cur_ch_q} + 5'(i);
      if (cand >= 5'(N_CH)) begin
        cand = cand - 5'(N_CH);
      end
      for (int k = 0; k < N_CH; k++) begin
        if (!hit && (cand == 5'(k)) && have_msg[k]) begin
          hit    = 1'b1;
          winner = 4'(k);
        end
      end
    end
  end

  always_comb begin
    win_len = '0;
    head    = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (winner == 4'(k)) begin
        win_len = len[8*k +: 8];
      end
      if (cur_ch_q == 4'(k)) begin
        head = out_data[8*k +: 8];
      end
    end
  end

  always_ff @(posedge sys_clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= S_IDLE;
      cur_ch_q <= 4'(N_CH - 1);
      cnt_q    <= '0;
`ifdef SPI_SCHED_CHECKSUM_EN
      csum_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cur_ch_q <= cur_ch_d;
      cnt_q    <= cnt_d;
`ifdef SPI_SCHED_CHECKSUM_EN
      csum_q   <= csum_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    cur_ch_d = cur_ch_q;
    cnt_d    = cnt_q;
`ifdef SPI_SCHED_CHECKSUM_EN
    csum_d   = csum_q;
`endif
    tx_valid = 1'b0;
    tx_data  = '0;

    case (state_q)
      S_IDLE: begin
        // A zero length (usedw lagging have_msg) still advances the pointer but opens no frame.
        if (hit) begin
          cur_ch_d = winner;
          cnt_d    = win_len;
`ifdef SPI_SCHED_CHECKSUM_EN
          csum_d   = '0;
`endif
          if (win_len != 8'd0) begin
            state_d = S_SYNC;
          end
        end
      end
      S_SYNC: begin
        tx_valid = 1'b1;
        tx_data  = SYNC_BYTE;
        if (tx_ready) begin
          state_d = S_ID;
        end
      end
      S_ID: begin
        tx_valid = 1'b1;
        tx_data  = ID_BASE + {4'b0000, cur_ch_q};
        if (tx_ready) begin
`ifdef SPI_SCHED_CHECKSUM_EN
          csum_d  = csum_q ^ tx_data;
`endif
          state_d = S_LEN;
        end
      end
      S_LEN: begin
        tx_valid = 1'b1;
        tx_data  = cnt_q;
        if (tx_ready) begin
`ifdef SPI_SCHED_CHECKSUM_EN
          csum_d  = csum_q ^ tx_data;
`endif
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        tx_valid = 1'b1;
        tx_data  = head;
        if (tx_ready) begin
`ifdef SPI_SCHED_CHECKSUM_EN
          csum_d = csum_q ^ tx_data;
`endif
          if (cnt_q != 8'd0) begin
            cnt_d = cnt_q - 8'd1;
          end
          if (cnt_q == 8'd1) begin
`ifdef SPI_SCHED_CHECKSUM_EN
            state_d = S_CSUM;
`else
            state_d = S_IDLE;
`endif
          end
        end
      end
`ifdef SPI_SCHED_CHECKSUM_EN
      S_CSUM: begin
        tx_valid = 1'b1;
        tx_data  = csum_q;
        if (tx_ready) begin
          state_d = S_IDLE;
        end
      end
`endif
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // The read strobe follows tx_ready directly so each accepted payload byte pops exactly one head.
  always_comb begin
    enc_rdreq = '0;
    for (int k = 0; k < N_CH; k++) begin
      enc_rdreq[k] = (state_q == S_DATA) && tx_ready && (cur_ch_q == 4'(k));
    end
  end

  assign busy   = (state_q != S_IDLE);
  assign cur_ch = cur_ch_q;

endmodule

// File: tb/tb_spi_msg_scheduler.sv
// Bench for spi_msg_scheduler: show-ahead FIFO models per channel, byte scoreboard, vector table.
module tb_spi_msg_scheduler;
  localparam int N = 4;

  logic           sys_clk = 1'b0;
  logic           n_rst;
  logic [N-1:0]   have_msg;
  logic [8*N-1:0] len;
  logic [8*N-1:0] out_data;
  logic [N-1:0]   enc_rdreq;
  logic [7:0]     tx_data;
  logic           tx_valid;
  logic           tx_ready;
  logic           busy;
  logic [3:0]     cur_ch;

  spi_msg_scheduler #(.N_CH(N)) dut (
    .sys_clk(sys_clk), .n_rst(n_rst), .have_msg(have_msg), .len(len),
    .out_data(out_data), .enc_rdreq(enc_rdreq), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy), .cur_ch(cur_ch)
  );

  always #5 sys_clk = ~sys_clk;

  logic [7:0] mem [N][512];
  int         wp [N];
  int         rp [N];
  int         rd_cnt [N];
  logic [N-1:0] lag;
  logic [N-1:0] pend;
  int         ready_pct;
  int         cyc;
  int         first_cyc, last_cyc;
  logic [7:0] sb [$];
  int         n_checks, n_pass;
  logic       stalled_prev;
  logic [7:0] prev_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic refresh();
    for (int k = 0; k < N; k++) begin
      int c;
      c = wp[k] - rp[k];
      have_msg[k]      = (c > 0);
      len[8*k +: 8]    = lag[k] ? 8'd0 : ((c > 255) ? 8'd255 : 8'(c));
      out_data[8*k +: 8] = mem[k][rp[k] % 512];
    end
  endtask

  // FIFO model, tx_ready driver and stream monitor share one process.
  initial begin
    refresh();
    tx_ready = 1'b0;
    forever begin
      @(negedge sys_clk);
      pend = '0;
      if (n_rst) begin
        if (tx_valid && tx_ready) begin
          if (first_cyc < 0) first_cyc = cyc;
          last_cyc = cyc;
          if (sb.size() == 0) chk("unexpected_byte", {24'd0, tx_data}, 32'hFFFF_FFFF);
          else chk("stream_byte", {24'd0, tx_data}, {24'd0, sb.pop_front()});
        end
        if (enc_rdreq != '0) begin
          chk("rdreq_onehot_on_xfer", {31'd0, $onehot(enc_rdreq) && tx_valid && tx_ready}, 32'd1);
          for (int k = 0; k < N; k++) if (enc_rdreq[k]) rd_cnt[k]++;
          pend = enc_rdreq;
        end
        if (stalled_prev) chk("stall_stable", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, prev_data});
        stalled_prev = tx_valid && !tx_ready;
        prev_data    = tx_data;
      end else begin
        stalled_prev = 1'b0;
      end
      @(posedge sys_clk);
      #1;
      for (int k = 0; k < N; k++) if (pend[k]) rp[k]++;
      tx_ready = ($urandom_range(99) < 32'(ready_pct));
      refresh();
      cyc++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge sys_clk);
    #2;
  endtask

  task automatic load(input int ch, input int n, input logic [7:0] b0);
    for (int i = 0; i < n; i++) begin
      mem[ch][wp[ch] % 512] = 8'(b0 * (i + 1));
      wp[ch]++;
    end
  endtask

  task automatic push_frame(input int ch, input int start, input int n,
                            input logic [7:0] id, input logic [7:0] lb);
    logic [7:0] cs;
    cs = id ^ lb;
    sb.push_back(8'hA5);
    sb.push_back(id);
    sb.push_back(lb);
    for (int i = 0; i < n; i++) begin
      sb.push_back(mem[ch][(start + i) % 512]);
      cs = cs ^ mem[ch][(start + i) % 512];
    end
`ifdef SPI_SCHED_CHECKSUM_EN
    sb.push_back(cs);
`endif
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((sb.size() != 0 || busy) && t < 3000) begin
      tick(1);
      t++;
    end
    chk("drain_in_budget", {31'd0, t < 3000}, 32'd1);
  endtask

  task automatic do_reset();
    n_rst = 1'b0;
    tick(3);
    n_rst = 1'b1;
    tick(1);
  endtask

  typedef struct {
    int         ch;
    int         n;
    logic [7:0] b0;
    int         rdy;
    logic [7:0] exp_id;
    logic [7:0] exp_len;
  } vec_t;

`ifdef SPI_SCHED_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif

  initial begin
    vec_t vt [5];
    int   start, rd0, t;

    vt[0] = '{ch: 2, n: 3,   b0: 8'h11, rdy: 100, exp_id: 8'h12, exp_len: 8'h03};
    vt[1] = '{ch: 2, n: 3,   b0: 8'h11, rdy: 50,  exp_id: 8'h12, exp_len: 8'h03};
    vt[2] = '{ch: 0, n: 1,   b0: 8'h5A, rdy: 100, exp_id: 8'h10, exp_len: 8'h01};
    vt[3] = '{ch: 3, n: 255, b0: 8'h07, rdy: 70,  exp_id: 8'h13, exp_len: 8'hFF};
    vt[4] = '{ch: 1, n: 4,   b0: 8'hC3, rdy: 30,  exp_id: 8'h11, exp_len: 8'h04};

    n_checks = 0; n_pass = 0; cyc = 0; first_cyc = -1; last_cyc = -1;
    lag = '0; pend = '0; ready_pct = 100; stalled_prev = 1'b0; prev_data = '0;
    for (int k = 0; k < N; k++) begin wp[k] = 0; rp[k] = 0; rd_cnt[k] = 0; end
    n_rst = 1'b0;

    // reset and idle
    tick(3);
    chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
    chk("rst_rdreq", {28'd0, enc_rdreq}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_cur_ch", {28'd0, cur_ch}, 32'd3);
    n_rst = 1'b1;
    tick(5);
    chk("idle_tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("idle_busy", {31'd0, busy}, 32'd0);

    // table of single-channel frames
    for (int v = 0; v < 5; v++) begin
      ready_pct = vt[v].rdy;
      rd0       = rd_cnt[vt[v].ch];
      start     = wp[vt[v].ch];
      first_cyc = -1;
      load(vt[v].ch, vt[v].n, vt[v].b0);
      push_frame(vt[v].ch, start, vt[v].n, vt[v].exp_id, vt[v].exp_len);
      drain();
      chk("frame_rdreq_count", 32'(rd_cnt[vt[v].ch] - rd0), 32'(vt[v].n));
      chk("frame_cur_ch", {28'd0, cur_ch}, 32'(vt[v].ch));
      if (vt[v].rdy == 100)
        chk("frame_gapless", 32'(last_cyc - first_cyc), 32'(vt[v].n + 2 + CS));
    end

    // round robin from reset: ch0..ch3 then ch0 again
    ready_pct = 100;
    do_reset();
    for (int k = 0; k < N; k++) begin
      start = wp[k];
      load(k, 1, 8'(8'h40 + k));
      push_frame(k, start, 1, 8'(8'h10 + k), 8'h01);
    end
    rd0 = rd_cnt[0];
    t = 0;
    while (rd_cnt[0] == rd0 && t < 100) begin tick(1); t++; end
    chk("rr_ch0_first_in_budget", {31'd0, t < 100}, 32'd1);
    start = wp[0];
    load(0, 1, 8'h4F);
    push_frame(0, start, 1, 8'h10, 8'h01);
    drain();
    chk("rr_final_cur_ch", {28'd0, cur_ch}, 32'd0);

    // length race: have_msg without a length yet
    do_reset();
    lag[1] = 1'b1;
    start  = wp[1];
    load(1, 2, 8'h66);
    tick(3);
    chk("race_no_frame", {31'd0, tx_valid}, 32'd0);
    chk("race_cur_ch", {28'd0, cur_ch}, 32'd1);
    lag[1] = 1'b0;
    push_frame(1, start, 2, 8'h11, 8'h02);
    drain();

    // reset after the first payload byte of a 4-byte frame
    do_reset();
    rd0   = rd_cnt[3];
    start = wp[3];
    load(3, 4, 8'h21);
    sb.push_back(8'hA5);
    sb.push_back(8'h13);
    sb.push_back(8'h04);
    sb.push_back(mem[3][start % 512]);
    t = 0;
    while (rd_cnt[3] == rd0 && t < 100) begin tick(1); t++; end
    chk("mid_first_pop_in_budget", {31'd0, t < 100}, 32'd1);
    chk("mid_partial_consumed", 32'(sb.size()), 32'd0);
    n_rst = 1'b0;
    #1;
    chk("mid_rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("mid_rst_rdreq", {28'd0, enc_rdreq}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_cur_ch", {28'd0, cur_ch}, 32'd3);
    tick(2);
    n_rst = 1'b1;
    push_frame(3, start + 1, 3, 8'h13, 8'h03);
    drain();
    chk("mid_total_pops", 32'(rd_cnt[3] - rd0), 32'd4);

    tick(3);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
